muxn_arb: RTL and testbench

- Parametrised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes.
- Generalises the 16-bit 2:1 select to CH channels.
- Channel choice is made by an internal arbiter, round-robin or fixed-priority, instead of an external select.
- Single-entry output register; sits between multiple datapath producers (ALU, memory read, I/O) and one shared consumer bus.

---
 rtl/muxn_arb.sv | 85 ++++++++
 tb/tb_muxn_arb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muxn_arb.sv
// CH-way registered mux with round-robin or fixed-priority arbitration.
// Latency: 1 cycle from input transfer to out_valid; 1 word/cycle sustained.
// Backpressure: a held entry with out_ready low blocks every in_ready.
module muxn_arb #(
    parameter int WIDTH = 16,
    parameter int CH    = 4,
    parameter int RR    = 1,
    localparam int SELW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH*WIDTH-1:0]   in_data,
    input  logic [CH-1:0]         in_valid,
    output logic [CH-1:0]         in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SELW-1:0]       out_sel
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  gsel;
    logic [CH-1:0]    grant;
    logic             found;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] mux_dat;

    assign load_en = !out_valid || out_ready;

    // Two-pass search: channels at or above the pointer first, then wrap to
    // the lowest valid channel. With the pointer held at 0 this degenerates
    // to plain lowest-index priority.
    always_comb begin
        grant = '0;
        gsel  = '0;
        found = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (!found && in_valid[i] && (SELW'(i) >= ptr)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                gsel     = SELW'(i);
            end
        end
        for (int i = 0; i < CH; i++) begin
            if (!found && in_valid[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                gsel     = SELW'(i);
            end
        end
    end

    assign in_ready = grant & {CH{load_en & rst_n}};
    assign xfer     = found & load_en;

    // AND-OR select keeps unselected channels (even X) off the datapath.
    always_comb begin
        mux_dat = '0;
        for (int i = 0; i < CH; i++) begin
            mux_dat = mux_dat | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= mux_dat;
                out_sel   <= gsel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (RR != 0 && CH > 1 && xfer) begin
                ptr <= (gsel == SELW'(CH - 1)) ? '0 : gsel + SELW'(1);
            end
        end
    end

endmodule

// File: tb/tb_muxn_arb.sv
// Bench for muxn_arb: round-robin and fixed-priority 4-channel instances plus a
// single-channel instance, checked against a queue-free behavioural model.
module tb_muxn_arb;

    logic        clk;
    logic        rst_n;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic        out_ready;
    logic [15:0] in1_data;
    logic [0:0]  in1_valid;
    logic        out1_ready;

    logic [3:0]  rr_rdy, fp_rdy;
    logic [15:0] rr_data, fp_data, one_data;
    logic        rr_valid, fp_valid, one_valid;
    logic [1:0]  rr_sel, fp_sel;
    logic [0:0]  one_rdy, one_sel;

    int checks = 0;
    int errors = 0;

    // model state: index 0 = round-robin instance, 1 = fixed-priority instance
    int          mptr;
    logic        mv [2];
    logic [15:0] md [2];
    int          ms [2];
    logic        o_v;
    logic [15:0] o_d;
    int          exp6 [4] = '{3, 0, 3, 0};

    muxn_arb #(.WIDTH(16), .CH(4), .RR(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rr_rdy), .out_data(rr_data), .out_valid(rr_valid),
        .out_ready(out_ready), .out_sel(rr_sel));

    muxn_arb #(.WIDTH(16), .CH(4), .RR(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(fp_rdy), .out_data(fp_data), .out_valid(fp_valid),
        .out_ready(out_ready), .out_sel(fp_sel));

    muxn_arb #(.WIDTH(16), .CH(1), .RR(1)) u_one (
        .clk(clk), .rst_n(rst_n), .in_data(in1_data), .in_valid(in1_valid),
        .in_ready(one_rdy), .out_data(one_data), .out_valid(one_valid),
        .out_ready(out1_ready), .out_sel(one_sel));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First valid channel at distance 0,1,2,3 from the priority pointer.
    function automatic int mgrant(input int ptr, input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mptr = 0;
        o_v  = 1'b0;
        o_d  = '0;
        for (int w = 0; w < 2; w++) begin
            mv[w] = 1'b0;
            md[w] = '0;
            ms[w] = 0;
        end
    endtask

    // Called just after a falling edge with inputs applied; checks in_ready,
    // crosses one rising edge, updates the model and checks the outputs.
    task automatic step();
        int          g [2];
        logic        ld [2];
        logic [3:0]  er;
        logic        ld1;
        #1;
        for (int w = 0; w < 2; w++) begin
            g[w]  = mgrant((w == 0) ? mptr : 0, in_valid);
            ld[w] = !mv[w] || out_ready;
            er    = (g[w] >= 0 && ld[w]) ? 4'(1 << g[w]) : 4'b0000;
            chk((w == 0) ? "rr_in_ready" : "fp_in_ready", (w == 0) ? rr_rdy : fp_rdy, 64'(er));
        end
        ld1 = !o_v || out1_ready;
        chk("one_in_ready", 64'(one_rdy), 64'(in1_valid[0] & ld1));
        @(posedge clk);
        for (int w = 0; w < 2; w++) begin
            if (g[w] >= 0 && ld[w]) begin
                mv[w] = 1'b1;
                md[w] = in_data[g[w]*16 +: 16];
                ms[w] = g[w];
                if (w == 0) mptr = (g[w] + 1) % 4;
            end else if (mv[w] && out_ready) begin
                mv[w] = 1'b0;
            end
        end
        if (in1_valid[0] && ld1) begin
            o_v = 1'b1;
            o_d = in1_data;
        end else if (o_v && out1_ready) begin
            o_v = 1'b0;
        end
        @(negedge clk);
        chk("rr_valid", 64'(rr_valid), 64'(mv[0]));
        chk("rr_data",  64'(rr_data),  64'(md[0]));
        chk("rr_sel",   64'(rr_sel),   64'(ms[0]));
        chk("fp_valid", 64'(fp_valid), 64'(mv[1]));
        chk("fp_data",  64'(fp_data),  64'(md[1]));
        chk("fp_sel",   64'(fp_sel),   64'(ms[1]));
        chk("one_valid", 64'(one_valid), 64'(o_v));
        chk("one_data",  64'(one_data),  64'(o_d));
        chk("one_sel",   64'(one_sel),   64'd0);
    endtask

    // Asynchronous reset applied mid-low-phase; outputs must clear without a clock.
    task automatic do_reset();
        in_valid  = 4'b1111;
        in1_valid = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("rst_rr_valid", 64'(rr_valid), 64'd0);
        chk("rst_rr_data",  64'(rr_data),  64'd0);
        chk("rst_rr_sel",   64'(rr_sel),   64'd0);
        chk("rst_rr_ready", 64'(rr_rdy),   64'd0);
        chk("rst_fp_ready", 64'(fp_rdy),   64'd0);
        chk("rst_one_valid", 64'(one_valid), 64'd0);
        chk("rst_one_ready", 64'(one_rdy),   64'd0);
        model_reset();
        in_valid  = 4'b0000;
        in1_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = '0;
        in_valid   = '0;
        out_ready  = 1'b1;
        in1_data   = '0;
        in1_valid  = '0;
        out1_ready = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // Test 2: single channel request
        in_data   = {16'h3333, 16'hBEEF, 16'h1111, 16'h0000};
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #1;
        chk("t2_in_ready", 64'(rr_rdy), 64'h4);
        step();
        chk("t2_data",  64'(rr_data),  64'hBEEF);
        chk("t2_sel",   64'(rr_sel),   64'd2);
        chk("t2_valid", 64'(rr_valid), 64'd1);

        // Test 1: reset mid-stream, then all-valid grant goes to ch0
        in_valid = 4'b1111;
        step();
        chk("t1_valid_before_rst", 64'(rr_valid), 64'd1);
        do_reset();
        in_valid = 4'b1111;
        step();
        chk("t1_first_sel", 64'(rr_sel), 64'd0);

        // Test 3: round-robin rotation, one word per cycle
        do_reset();
        in_data   = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            step();
            chk("t3_sel",   64'(rr_sel),   64'(n % 4));
            chk("t3_data",  64'(rr_data),  64'(n % 4));
            chk("t3_valid", 64'(rr_valid), 64'd1);
        end

        // Test 4: backpressure hold, then same-cycle refill from the next channel
        do_reset();
        in_data  = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'h1234};
        in_valid = 4'b1111;
        step();
        chk("t4_loaded", 64'(rr_data), 64'h1234);
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("t4_hold_ready", 64'(rr_rdy),  64'd0);
            chk("t4_hold_data",  64'(rr_data), 64'h1234);
            chk("t4_hold_valid", 64'(rr_valid), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("t4_refill_ready", 64'(rr_rdy), 64'h2);
        step();
        chk("t4_refill_sel",  64'(rr_sel),  64'd1);
        chk("t4_refill_data", 64'(rr_data), 64'hBBBB);

        // Test 5: fixed priority starves channel 3
        in_valid = 4'b1010;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("t5_fp_sel",  64'(fp_sel),    64'd1);
            chk("t5_fp_rdy3", 64'(fp_rdy[3]), 64'd0);
        end

        // Test 6: wrap from pointer 3 with only ch3/ch0 requesting
        do_reset();
        in_valid = 4'b0100;
        step();
        in_valid = 4'b1001;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("t6_wrap_sel", 64'(rr_sel), 64'(exp6[n]));
        end

        // Single-channel instance: one-cycle latency, out_sel fixed at 0
        in1_data   = 16'hA5A5;
        in1_valid  = 1'b1;
        out1_ready = 1'b1;
        step();
        chk("ch1_data",  64'(one_data),  64'hA5A5);
        chk("ch1_valid", 64'(one_valid), 64'd1);
        chk("ch1_sel",   64'(one_sel),   64'd0);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            in_data    = {$urandom, $urandom};
            in_valid   = 4'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            in1_data   = 16'($urandom);
            in1_valid  = 1'($urandom);
            out1_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
